// File: rtl/ctrl_pkg.sv
// Shared types and instruction-field positions for the control sequencer.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ALU  = 4'h1,
    OP_ALUI = 4'h2,
    OP_LDI  = 4'h3,
    OP_BRC  = 4'h4,
    OP_JMP  = 4'h5,
    OP_HALT = 4'hF
  } opcode_t;

  localparam int unsigned INSTR_W = 24;
  localparam int unsigned OP_LSB  = 20;
  localparam int unsigned FN_LSB  = 16;
  localparam int unsigned RD_LSB  = 12;
  localparam int unsigned RA_LSB  = 8;
  localparam int unsigned RB_LSB  = 4;
  localparam int unsigned IMM_LSB = 0;

  function automatic logic writes_reg(input logic [3:0] op);
    return (op == OP_ALU) || (op == OP_ALUI) || (op == OP_LDI);
  endfunction

  function automatic logic runs_exec(input logic [3:0] op);
    return op <= OP_JMP;
  endfunction

endpackage

// File: rtl/branch_eval.sv
// Selects one comparator flag by function code; codes above 4 never branch.
module branch_eval (
  input  logic [4:0] compared,
  input  logic [2:0] fn_sel,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    if (fn_sel <= 3'd4) taken = compared[fn_sel];
  end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute/writeback sequencer; only pc, ir and state are stored.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned PC_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                instr_req,
  output logic [PC_W-1:0]     instr_addr,
  input  logic                instr_valid,
  input  logic [INSTR_W-1:0]  instr_data,
  input  logic [4:0]          compared,
  output logic [3:0]          SRD,
  output logic [3:0]          SBA,
  output logic [3:0]          SBB,
  output logic [3:0]          SULA,
  output logic [1:0]          selMuxCTE,
  output logic [7:0]          CTE,
  output logic                LE,
  output logic                busy,
  output logic                halted,
  output logic                illegal
);

  state_t               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;

  logic [3:0]           op;
  logic [7:0]           imm;
  logic [PC_W-1:0]      imm_pc;
  logic [PC_W-1:0]      pc_inc;
  logic                 br_taken;

  assign op     = ir_q[OP_LSB +: 4];
  assign imm    = ir_q[IMM_LSB +: 8];
  assign imm_pc = PC_W'(imm);
  assign pc_inc = pc_q + PC_W'(1);

  branch_eval u_branch_eval (
    .compared (compared),
    .fn_sel   (ir_q[FN_LSB +: 3]),
    .taken    (br_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = runs_exec(op) ? S_EXEC : S_HALT;
      S_EXEC: begin
        // Register-writing ops defer the pc update to WB.
        if (writes_reg(op)) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
          case (op)
            OP_BRC:  pc_d = br_taken ? imm_pc : pc_inc;
            OP_JMP:  pc_d = imm_pc;
            default: pc_d = pc_inc;
          endcase
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    instr_req  = (state_q == S_FETCH);
    instr_addr = pc_q;
    busy       = (state_q != S_IDLE) && (state_q != S_HALT);
    halted     = (state_q == S_HALT);
    illegal    = (state_q == S_HALT) && (op != OP_HALT);
    LE         = (state_q == S_WB);
    SRD        = '0;
    SBA        = '0;
    SBB        = '0;
    SULA       = '0;
    selMuxCTE  = 2'b00;
    CTE        = '0;
    if ((state_q == S_DECODE) || (state_q == S_EXEC) || (state_q == S_WB)) begin
      SBA  = ir_q[RA_LSB +: 4];
      SBB  = ir_q[RB_LSB +: 4];
      SULA = ir_q[FN_LSB +: 4];
      if (writes_reg(op)) SRD = ir_q[RD_LSB +: 4];
      case (op)
        OP_ALUI: begin
          selMuxCTE = 2'b10;
          CTE       = imm;
        end
        OP_LDI: begin
          selMuxCTE = 2'b11;
          CTE       = imm;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with a cycle-by-cycle behavioural reference.
module tb_control_sequencer;

  localparam int unsigned PC_W = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            start = 1'b0;
  logic            instr_valid = 1'b0;
  logic [23:0]     instr_data = '0;
  logic [4:0]      compared = '0;
  logic            instr_req;
  logic [PC_W-1:0] instr_addr;
  logic [3:0]      SRD, SBA, SBB, SULA;
  logic [1:0]      selMuxCTE;
  logic [7:0]      CTE;
  logic            LE, busy, halted, illegal;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  control_sequencer #(.PC_W(PC_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .instr_req   (instr_req),
    .instr_addr  (instr_addr),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .compared    (compared),
    .SRD         (SRD),
    .SBA         (SBA),
    .SBB         (SBB),
    .SULA        (SULA),
    .selMuxCTE   (selMuxCTE),
    .CTE         (CTE),
    .LE          (LE),
    .busy        (busy),
    .halted      (halted),
    .illegal     (illegal)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: running/halted flags, pc, the current instruction and how many
  // cycles it has been in flight (0 = still being fetched).
  bit          m_run = 1'b0, m_halt = 1'b0, m_ill = 1'b0;
  int          m_age = 0;
  logic [7:0]  m_pc = '0;
  logic [23:0] m_ir = '0;
  logic [3:0]  m_op;
  int          m_len;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 1'b0; m_halt = 1'b0; m_ill = 1'b0;
      m_age = 0; m_pc = '0; m_ir = '0;
    end else if (m_run) begin
      if (m_age == 0) begin
        if (instr_valid) begin
          m_ir  = instr_data;
          m_age = 1;
        end
      end else begin
        m_op  = m_ir[23:20];
        m_len = (m_op >= 4'h1 && m_op <= 4'h3) ? 3 : 2;
        if (m_op > 4'h5) begin
          m_run  = 1'b0;
          m_halt = 1'b1;
          m_ill  = (m_op != 4'hF);
        end else if (m_age < m_len) begin
          m_age++;
        end else begin
          m_age = 0;
          if (m_op == 4'h5)
            m_pc = m_ir[7:0];
          else if (m_op == 4'h4 && m_ir[18:16] <= 3'd4 && compared[m_ir[18:16]])
            m_pc = m_ir[7:0];
          else
            m_pc = m_pc + 8'd1;
        end
      end
    end else if (!m_halt && start) begin
      m_run = 1'b1;
      m_pc  = '0;
      m_age = 0;
    end
  end

  logic [3:0] c_op;
  bit         c_dp, c_wr, c_imm;

  always @(negedge clk) begin
    if (rst_n) begin
      c_op  = m_ir[23:20];
      c_dp  = m_run && (m_age > 0);
      c_wr  = c_dp && (c_op >= 4'h1) && (c_op <= 4'h3);
      c_imm = c_dp && ((c_op == 4'h2) || (c_op == 4'h3));
      check("busy",       32'(busy),       32'(m_run));
      check("halted",     32'(halted),     32'(m_halt));
      check("illegal",    32'(illegal),    32'(m_ill));
      check("instr_req",  32'(instr_req),  32'(m_run && m_age == 0));
      check("instr_addr", 32'(instr_addr), 32'(m_pc));
      check("SBA",        32'(SBA),        32'(c_dp ? m_ir[11:8] : 4'h0));
      check("SBB",        32'(SBB),        32'(c_dp ? m_ir[7:4] : 4'h0));
      check("SULA",       32'(SULA),       32'(c_dp ? m_ir[19:16] : 4'h0));
      check("SRD",        32'(SRD),        32'(c_wr ? m_ir[15:12] : 4'h0));
      check("selMuxCTE",  32'(selMuxCTE),  32'(!c_dp ? 2'b00 : (c_op == 4'h2) ? 2'b10 :
                                              (c_op == 4'h3) ? 2'b11 : 2'b00));
      check("CTE",        32'(CTE),        32'(c_imm ? m_ir[7:0] : 8'h00));
      check("LE",         32'(LE),         32'(c_wr && m_age == 3));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic fetch(input logic [23:0] d, input int stall);
    repeat (stall) tick(1);
    instr_valid = 1'b1;
    instr_data  = d;
    tick(1);
    instr_valid = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_req"},  32'(instr_req),  32'd0);
    check({tag, "_addr"}, 32'(instr_addr), 32'd0);
    check({tag, "_LE"},   32'(LE),         32'd0);
    check({tag, "_busy"}, 32'(busy),       32'd0);
    check({tag, "_halt"}, 32'(halted),     32'd0);
    check({tag, "_ill"},  32'(illegal),    32'd0);
    check({tag, "_dp"},   32'({SRD, SBA, SBB, SULA, selMuxCTE, CTE}), 32'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2 check_quiet("reset");
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // ALU reg-reg, instruction accepted on the second fetch cycle
    do_start();
    fetch(24'h123120, 1);
    @(negedge clk);
    check("alu_SBA", 32'(SBA), 32'd1);
    check("alu_SBB", 32'(SBB), 32'd2);
    check("alu_SULA", 32'(SULA), 32'd2);
    check("alu_sel", 32'(selMuxCTE), 32'd0);
    check("alu_LE_dec", 32'(LE), 32'd0);
    tick(2);
    @(negedge clk);
    check("alu_LE_wb", 32'(LE), 32'd1);
    check("alu_SRD_wb", 32'(SRD), 32'd3);
    tick(1);
    @(negedge clk);
    check("alu_next_addr", 32'(instr_addr), 32'd1);
    check("alu_LE_after", 32'(LE), 32'd0);

    // LDI behind a 4-cycle fetch stall
    repeat (4) begin
      tick(1);
      @(negedge clk);
      check("stall_req", 32'(instr_req), 32'd1);
    end
    fetch(24'h30507F, 0);
    @(negedge clk);
    check("ldi_CTE", 32'(CTE), 32'h7F);
    check("ldi_sel", 32'(selMuxCTE), 32'd3);
    tick(2);
    @(negedge clk);
    check("ldi_LE", 32'(LE), 32'd1);
    check("ldi_SRD", 32'(SRD), 32'd5);
    tick(1);
    @(negedge clk);
    check("ldi_LE_after", 32'(LE), 32'd0);
    check("ldi_next_addr", 32'(instr_addr), 32'd2);

    // Branches: eq taken, eq not taken, fn=5 never, gt taken, fn[2:0]=7 never
    compared = 5'b00100; fetch(24'h420040, 0); tick(2); @(negedge clk);
    check("brc_eq_taken", 32'(instr_addr), 32'h40);
    compared = 5'b00011; fetch(24'h420040, 0); tick(2); @(negedge clk);
    check("brc_eq_not", 32'(instr_addr), 32'h41);
    compared = 5'b11111; fetch(24'h450040, 0); tick(2); @(negedge clk);
    check("brc_fn5_never", 32'(instr_addr), 32'h42);
    compared = 5'b10000; fetch(24'h440010, 0); tick(2); @(negedge clk);
    check("brc_gt_taken", 32'(instr_addr), 32'h10);
    compared = 5'b11111; fetch(24'h4F0040, 0); tick(2); @(negedge clk);
    check("brc_fn7_never", 32'(instr_addr), 32'h11);
    compared = 5'b00000;

    // JMP to the top of the address space, then NOP wraps to 0
    fetch(24'h5000FF, 0); tick(2); @(negedge clk);
    check("jmp_ff", 32'(instr_addr), 32'hFF);
    fetch(24'h000000, 0); tick(2); @(negedge clk);
    check("nop_wrap", 32'(instr_addr), 32'h00);

    // ALU reg-imm with instr_valid held high (and ignored) while executing
    fetch(24'h2345A5, 2);
    instr_valid = 1'b1;
    instr_data  = 24'h9FFFFF;
    tick(2);
    instr_valid = 1'b0;
    @(negedge clk);
    check("alui_CTE", 32'(CTE), 32'hA5);
    check("alui_sel", 32'(selMuxCTE), 32'd2);
    check("alui_SRD", 32'(SRD), 32'd4);
    tick(1);
    @(negedge clk);
    check("alui_next_addr", 32'(instr_addr), 32'd1);

    // HALT, and start ignored afterwards
    fetch(24'hF00000, 0);
    tick(1);
    @(negedge clk);
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_busy", 32'(busy), 32'd0);
    check("halt_ill", 32'(illegal), 32'd0);
    start = 1'b1;
    tick(3);
    start = 1'b0;
    @(negedge clk);
    check("halt_sticky", 32'(halted), 32'd1);
    check("halt_no_req", 32'(instr_req), 32'd0);

    // Illegal opcode
    rst_n = 1'b0;
    tick(1);
    @(negedge clk);
    check_quiet("reset2");
    rst_n = 1'b1;
    tick(1);
    do_start();
    fetch(24'h900000, 0);
    tick(1);
    @(negedge clk);
    check("ill_illegal", 32'(illegal), 32'd1);
    check("ill_halted", 32'(halted), 32'd1);
    check("ill_busy", 32'(busy), 32'd0);

    // Reset asserted in the middle of a writeback
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    do_start();
    fetch(24'h178AB0, 0);
    tick(2);
    #1 check("wb_LE_pre", 32'(LE), 32'd1);
    rst_n = 1'b0;
    #1 check_quiet("midwb");
    tick(1);
    rst_n = 1'b1;
    tick(1);
    do_start();
    @(negedge clk);
    check("restart_req", 32'(instr_req), 32'd1);
    check("restart_addr", 32'(instr_addr), 32'd0);
    fetch(24'h000000, 0);
    tick(2);
    @(negedge clk);
    check("restart_nop", 32'(instr_addr), 32'd1);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter PC_W, default 8: program-counter / instruction-address width.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  leave IDLE and begin fetching at pc=0.
REQ-005 instr_req  output  1  fetch request to instruction memory.
REQ-006 instr_addr  output  PC_W  fetch address, equal to pc.
REQ-007 instr_valid  input  1  instr_data is valid this cycle.
REQ-008 instr_data  input  24  instruction: [23:20] op, [19:16] fn, [15:12] rd, [11:8] ra, [7:4] rb, [7:0] imm.
REQ-009 compared  input  5  datapath comparator flags: [0] lt, [1] le, [2] eq, [3] ge, [4] gt.
REQ-010 SRD, SBA, SBB, SULA  output  4 each  register-bank destination, A/B sources, ALU function.
REQ-011 selMuxCTE  output  2  constant-mux select: 00 regs, 10 B=CTE, 11 both=CTE.
REQ-012 CTE  output  8  constant to datapath.
REQ-013 LE  output  1  register-bank write enable.
REQ-014 busy, halted, illegal  output  1 each  status.

Function
REQ-015 States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
REQ-016 IDLE->FETCH on start=1, pc<=0; otherwise remain in IDLE.
REQ-017 FETCH: instr_req=1 and instr_addr=pc every FETCH cycle; on instr_valid=1, latch instr_data into ir and go to DECODE; otherwise stay in FETCH, with no timeout.
REQ-018 instr_valid outside FETCH is ignored.
REQ-019 DECODE: drive SBA=ir.ra, SBB=ir.rb, SULA=ir.fn, and selMuxCTE/CTE per op; hold these through EXEC and WB.
REQ-020 op 0 NOP: pc+1, next state FETCH.
REQ-021 op 1 ALU reg-reg: selMuxCTE=00; WB with SRD=rd.
REQ-022 op 2 ALU reg-imm: selMuxCTE=10, CTE=imm; WB with SRD=rd.
REQ-023 op 3 LDI: selMuxCTE=11, CTE=imm, SULA=fn; WB with SRD=rd.
REQ-024 op 4 BRC: selMuxCTE=00; in EXEC, if compared[fn[2:0]]=1 then pc<=imm[PC_W-1:0], else pc<=pc+1.
REQ-025 op 4 BRC with fn[2:0]>4: branch never taken.
REQ-026 op 5 JMP: pc<=imm unconditionally, no write.
REQ-027 op F HALT: go to HALT; halted=1 until reset.
REQ-028 All other ops: illegal=1 (sticky), go to HALT.
REQ-029 Latency, ALU/LDI: DECODE, EXEC, WB = 3 cycles after instr_valid, then FETCH.
REQ-030 Latency, NOP/BRC/JMP: DECODE, EXEC = 2 cycles, then FETCH.
REQ-031 LE=1 for exactly one cycle, in WB only; LE=0 in all other states.
REQ-032 pc increments modulo 2^PC_W (0xFF+1 -> 0x00).
REQ-033 busy=1 in every state except IDLE and HALT.
REQ-034 start while busy or halted is ignored.

Reset
REQ-035 rst_n=0 forces immediately, in any state: state=IDLE, pc=0, ir=0, all datapath outputs 0, selMuxCTE=00, instr_req=0.
REQ-036 The same reset also forces LE=0, busy=0, halted=0, illegal=0.
REQ-037 Reset asserted during WB suppresses the write; no partial LE pulse remains after reset.

Structure
REQ-038 Shared package ctrl_pkg holds the state enum, opcode enum, and instruction-field bit positions.
REQ-039 One sub-module, branch_eval: combinational selection of compared by fn, including the out-of-range rule in REQ-025.
REQ-040 pc, ir and state are the only registered state; outputs decode from ir and state.

Verification
REQ-041 ALU reg-reg: start; instr 0x1_2_3_1_2_0 with instr_valid on cycle 2 -> SBA=1, SBB=2, SULA=2, selMuxCTE=00, LE=1 with SRD=3 exactly 3 cycles later, then instr_addr=1.
REQ-042 LDI plus fetch stall: instr 0x3_0_5_0_7F held off 4 cycles -> instr_req stays high 4 extra cycles; then CTE=0x7F, selMuxCTE=11, SRD=5, single LE pulse.
REQ-043 BRC on eq: fn=2, imm=0x40, compared=00100 -> next instr_addr=0x40; repeat with compared=00011 -> pc+1.
REQ-044 Wrap-around: JMP to 0xFF, then NOP at 0xFF -> next instr_addr=0x00.
REQ-045 HALT and illegal: op F -> halted=1, busy=0, start ignored; op 9 -> illegal=1, halted=1.
REQ-046 Reset mid-WB: drop rst_n during WB -> LE=0 immediately, state IDLE, all outputs 0, restart from pc=0 after start.
